// File: rtl/pool_feature_fsm.sv
// Max-pool + ReLU + requantize stage: reads POOL_SIZE conv words per channel,
// keeps a running max (floored at 0), shifts and saturates, writes one feature per channel.
module pool_feature_fsm #(
    parameter int IN_WIDTH     = 32,
    parameter int DATA_WIDTH   = 24,
    parameter int NUM_CHANNELS = 6,
    parameter int POOL_SIZE    = 4,
    parameter int SHIFT        = 8,
    parameter int ADDR_WIDTH   = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_WIDTH-1:0]      conv_rd_addr,
    input  logic signed [IN_WIDTH-1:0] conv_rd_data,
    output logic                       feat_wen,
    output logic [ADDR_WIDTH-1:0]      feat_addr,
    output logic [DATA_WIDTH-1:0]      feat_din
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WRITE,
        ALL_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_CH  = ADDR_WIDTH'(NUM_CHANNELS - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_WIN = ADDR_WIDTH'(POOL_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] POOL_A   = ADDR_WIDTH'(POOL_SIZE);
    localparam logic [IN_WIDTH-1:0]   SAT_MAX  = IN_WIDTH'((64'd1 << (DATA_WIDTH - 1)) - 64'd1);

    state_t                     state, state_nxt;
    logic [ADDR_WIDTH-1:0]      ch_pos, ch_nxt;
    logic [ADDR_WIDTH-1:0]      win_pos, win_nxt;
    logic [ADDR_WIDTH-1:0]      addr_nxt;
    logic signed [IN_WIDTH-1:0] run_max, max_nxt;
    logic [IN_WIDTH-1:0]        shifted;
    logic [DATA_WIDTH-1:0]      sat_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ch_pos       <= '0;
            win_pos      <= '0;
            run_max      <= '0;
            conv_rd_addr <= '0;
        end else begin
            state        <= state_nxt;
            ch_pos       <= ch_nxt;
            win_pos      <= win_nxt;
            run_max      <= max_nxt;
            conv_rd_addr <= addr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ch_nxt    = ch_pos;
        win_nxt   = win_pos;
        max_nxt   = run_max;
        addr_nxt  = conv_rd_addr;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RD_ADDR;
                    ch_nxt    = '0;
                    win_nxt   = '0;
                    max_nxt   = '0;
                end
            end
            RD_ADDR: state_nxt = RD_DATA;
            RD_DATA: begin
                // Max starts at 0, so negative words never win: this is the ReLU.
                if (conv_rd_data > run_max) max_nxt = conv_rd_data;
                if (win_pos == LAST_WIN) begin
                    state_nxt = WRITE;
                end else begin
                    win_nxt   = win_pos + 1'b1;
                    state_nxt = RD_ADDR;
                end
            end
            WRITE: begin
                max_nxt = '0;
                win_nxt = '0;
                if (ch_pos == LAST_CH) begin
                    state_nxt = ALL_DONE;
                end else begin
                    ch_nxt    = ch_pos + 1'b1;
                    state_nxt = RD_ADDR;
                end
            end
            ALL_DONE: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
        // Address is registered on entry to RD_ADDR so the buffer sees it a full cycle early.
        if (state_nxt == RD_ADDR) addr_nxt = ch_nxt * POOL_A + win_nxt;
    end

    assign shifted = $unsigned(run_max >>> SHIFT);
    assign sat_val = (shifted > SAT_MAX) ? SAT_MAX[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];

    assign busy      = (state != IDLE);
    assign done      = (state == ALL_DONE);
    assign feat_wen  = (state == WRITE);
    assign feat_addr = feat_wen ? ch_pos : '0;
    assign feat_din  = feat_wen ? sat_val : '0;

endmodule

// File: tb/tb_pool_feature_fsm.sv
// Self-checking bench for pool_feature_fsm: default build plus a SHIFT=4 build sharing
// stimulus, checked against a channel-level max/ReLU/divide/clamp reference model.
module tb_pool_feature_fsm;

    localparam int IW       = 32;
    localparam int DW       = 24;
    localparam int NCH      = 6;
    localparam int PS       = 4;
    localparam int AW       = 5;
    localparam int NWORDS   = NCH * PS;
    localparam int PASS_CYC = NCH * (2 * PS + 1);
    localparam longint SAT  = (longint'(1) << (DW - 1)) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;

    logic          busy, done, feat_wen;
    logic [AW-1:0] conv_rd_addr, feat_addr;
    logic [DW-1:0] feat_din;
    logic          busy_s4, done_s4, feat_wen_s4;
    logic [AW-1:0] conv_rd_addr_s4, feat_addr_s4;
    logic [DW-1:0] feat_din_s4;

    logic signed [IW-1:0] conv_mem [32];
    logic signed [IW-1:0] rd_data = '0;
    logic signed [IW-1:0] rd_data_s4 = '0;

    int n_compared = 0;
    int n_mismatched = 0;
    int cyc = 0;
    int done_cnt = 0;

    typedef struct {
        longint addr;
        longint din;
        int     cyc;
    } wr_t;

    wr_t    wr_q[$];
    longint din4_q[$];
    longint addr_q[$];

    pool_feature_fsm dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .conv_rd_addr(conv_rd_addr), .conv_rd_data(rd_data),
        .feat_wen(feat_wen), .feat_addr(feat_addr), .feat_din(feat_din)
    );

    pool_feature_fsm #(.SHIFT(4)) dut_s4 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_s4), .done(done_s4),
        .conv_rd_addr(conv_rd_addr_s4), .conv_rd_data(rd_data_s4),
        .feat_wen(feat_wen_s4), .feat_addr(feat_addr_s4), .feat_din(feat_din_s4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        rd_data    <= conv_mem[conv_rd_addr];
        rd_data_s4 <= conv_mem[conv_rd_addr_s4];
    end

    // Passive monitor: logs writes, read addresses and done pulses away from the clock edge.
    always @(negedge clk) begin
        wr_t w;
        if (feat_wen) begin
            w.addr = longint'(feat_addr);
            w.din  = longint'(feat_din);
            w.cyc  = cyc;
            wr_q.push_back(w);
        end
        if (feat_wen_s4) din4_q.push_back(longint'(feat_din_s4));
        if (busy && !feat_wen && !done) addr_q.push_back(longint'(conv_rd_addr));
        if (done) done_cnt++;
    end

    function automatic longint ref_feature(input int ch, input int shift);
        longint m = 0;
        for (int w = 0; w < PS; w++)
            if (longint'(conv_mem[ch*PS + w]) > m) m = longint'(conv_mem[ch*PS + w]);
        m = m / (longint'(1) << shift);
        return (m > SAT) ? SAT : m;
    endfunction

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic clear_monitor();
        wr_q.delete();
        din4_q.delete();
        addr_q.delete();
        done_cnt = 0;
    endtask

    task automatic load_zero();
        for (int i = 0; i < 32; i++) conv_mem[i] = '0;
    endtask

    task automatic load_random();
        load_zero();
        for (int i = 0; i < NWORDS; i++) begin
            case ($urandom_range(0, 2))
                0:       conv_mem[i] = $urandom;
                1:       conv_mem[i] = $signed($urandom_range(0, 4000)) - 32'sd2000;
                default: conv_mem[i] = $urandom_range(0, 32'h7FFF_FFFF);
            endcase
        end
    endtask

    // One start pulse, then wait for done; optional stray starts at +10 and +30.
    task automatic applyStimulus(input bit busy_pulses, output int done_rel);
        int start_cyc;
        done_rel = -1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
        for (int k = 0; k < PASS_CYC + 20; k++) begin
            if (done) begin
                done_rel = cyc - start_cyc;
                break;
            end
            start = busy_pulses && (k == 10 || k == 30);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic checkPass(input string name, input int done_rel);
        checkOutput({name, "/latency"}, longint'(done_rel), longint'(PASS_CYC));
        repeat (3) @(negedge clk);
        checkOutput({name, "/done_count"}, longint'(done_cnt), 64'sd1);
        checkOutput({name, "/busy_idle"}, longint'(busy), 64'sd0);
        checkOutput({name, "/write_count"}, longint'(wr_q.size()), longint'(NCH));
        checkOutput({name, "/write_count_s4"}, longint'(din4_q.size()), longint'(NCH));
        for (int i = 0; i < NCH && i < wr_q.size(); i++) begin
            checkOutput($sformatf("%s/waddr%0d", name, i), wr_q[i].addr, longint'(i));
            checkOutput($sformatf("%s/din%0d", name, i), wr_q[i].din, ref_feature(i, 8));
            if (i > 0)
                checkOutput($sformatf("%s/spacing%0d", name, i),
                            longint'(wr_q[i].cyc - wr_q[i-1].cyc), longint'(2*PS + 1));
        end
        for (int i = 0; i < NCH && i < din4_q.size(); i++)
            checkOutput($sformatf("%s/din_s4_%0d", name, i), din4_q[i], ref_feature(i, 4));
        checkOutput({name, "/rdaddr_count"}, longint'(addr_q.size()), longint'(2*NWORDS));
        for (int i = 0; i < 2*NWORDS && i < addr_q.size(); i++)
            checkOutput($sformatf("%s/rdaddr%0d", name, i), addr_q[i], longint'(i / 2));
    endtask

    initial begin
        int rel;
        bit reached;

        load_zero();
        repeat (2) @(negedge clk);
        checkOutput("reset/busy", longint'(busy), 64'sd0);
        checkOutput("reset/done", longint'(done), 64'sd0);
        checkOutput("reset/feat_wen", longint'(feat_wen), 64'sd0);
        checkOutput("reset/feat_addr", longint'(feat_addr), 64'sd0);
        checkOutput("reset/feat_din", longint'(feat_din), 64'sd0);
        checkOutput("reset/conv_rd_addr", longint'(conv_rd_addr), 64'sd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] basic pass");
        clear_monitor();
        conv_mem[0] = 32'sd100;
        conv_mem[1] = -32'sd5000;
        conv_mem[2] = 32'sd2560;
        conv_mem[3] = 32'sd512;
        applyStimulus(1'b0, rel);
        checkPass("basic", rel);
        if (wr_q.size() > 0) checkOutput("basic/din0_const", wr_q[0].din, 64'sd10);

        $display("[TB] relu and extremes pass");
        clear_monitor();
        load_zero();
        conv_mem[12] = -32'sd1;
        conv_mem[13] = -32'sd256;
        conv_mem[14] = 32'sh8000_0000;
        conv_mem[15] = -32'sd7;
        conv_mem[16] = 32'sh1000_0000;
        conv_mem[20] = 32'sh7FFF_FFFF;
        applyStimulus(1'b0, rel);
        checkPass("extreme", rel);
        if (wr_q.size() == NCH) begin
            checkOutput("extreme/relu_ch3", wr_q[3].din, 64'sd0);
            checkOutput("extreme/max_ch5", wr_q[5].din, 64'sd8388607);
        end
        if (din4_q.size() == NCH) checkOutput("extreme/clamp_s4_ch4", din4_q[4], 64'sd8388607);

        $display("[TB] start while busy");
        clear_monitor();
        load_random();
        applyStimulus(1'b1, rel);
        checkPass("busy_start", rel);
        repeat (PASS_CYC) @(negedge clk);
        checkOutput("busy_start/no_restart_done", longint'(done_cnt), 64'sd1);

        for (int p = 0; p < 3; p++) begin
            $display("[TB] random pass %0d", p);
            clear_monitor();
            load_random();
            applyStimulus(1'b0, rel);
            checkPass($sformatf("rand%0d", p), rel);
        end

        $display("[TB] reset mid-pass");
        clear_monitor();
        load_random();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reached = 1'b0;
        for (int k = 0; k < PASS_CYC; k++) begin
            if (wr_q.size() >= 3) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("abort/reached_third_write", longint'(reached), 64'sd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort/busy", longint'(busy), 64'sd0);
        checkOutput("abort/done", longint'(done), 64'sd0);
        checkOutput("abort/feat_wen", longint'(feat_wen), 64'sd0);
        checkOutput("abort/feat_addr", longint'(feat_addr), 64'sd0);
        checkOutput("abort/feat_din", longint'(feat_din), 64'sd0);
        checkOutput("abort/conv_rd_addr", longint'(conv_rd_addr), 64'sd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (PASS_CYC + 10) @(negedge clk);
        checkOutput("abort/write_count", longint'(wr_q.size()), 64'sd3);
        checkOutput("abort/done_count", longint'(done_cnt), 64'sd0);
        checkOutput("abort/no_resume", longint'(busy), 64'sd0);

        clear_monitor();
        load_random();
        applyStimulus(1'b0, rel);
        checkPass("after_abort", rel);

        $display("[TB] start held through done");
        clear_monitor();
        @(negedge clk);
        start = 1'b1;
        reached = 1'b0;
        for (int k = 0; k < PASS_CYC + 20; k++) begin
            @(negedge clk);
            if (done) begin
                reached = 1'b1;
                break;
            end
        end
        checkOutput("held/first_done", longint'(reached), 64'sd1);
        @(negedge clk);
        checkOutput("held/idle_gap", longint'(busy), 64'sd0);
        @(negedge clk);
        checkOutput("held/restart", longint'(busy), 64'sd1);
        start = 1'b0;
        reached = 1'b0;
        for (int k = 0; k < PASS_CYC + 20; k++) begin
            @(negedge clk);
            if (done) begin
                reached = 1'b1;
                break;
            end
        end
        checkOutput("held/second_done", longint'(reached), 64'sd1);
        repeat (3) @(negedge clk);
        checkOutput("held/write_count", longint'(wr_q.size()), longint'(2*NCH));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/pool_feature_fsm.md
POOL_FEATURE_FSM -- requirements
Module: pool_feature_fsm

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32: signed width of convolution accumulator words read from the conv output buffer.
REQ-002 SHALL have parameter DATA_WIDTH, default 24: width of feature words written to the dense-stage feature BRAM.
REQ-003 SHALL have parameter NUM_CHANNELS, default 6: features produced, one per channel.
REQ-004 SHALL have parameter POOL_SIZE, default 4: conv words max-pooled per channel.
REQ-005 SHALL have parameter SHIFT, default 8: arithmetic right-shift requantization amount, range 0..IN_WIDTH-1.
REQ-006 SHALL have parameter ADDR_WIDTH, default 5: width of all address ports.
REQ-007 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-008 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port start  input  1  begin one pooling pass; sampled only in IDLE.
REQ-010 SHALL have port busy  output  1  high in every state other than IDLE.
REQ-011 SHALL have port done  output  1  single-cycle pass-complete pulse.
REQ-012 SHALL have port conv_rd_addr  output  ADDR_WIDTH  conv buffer read address.
REQ-013 SHALL have port conv_rd_data  input  IN_WIDTH  conv buffer read data, signed, valid one cycle after conv_rd_addr is clocked.
REQ-014 SHALL have port feat_wen  output  1  feature BRAM port-A write enable.
REQ-015 SHALL have port feat_addr  output  ADDR_WIDTH  feature BRAM port-A address.
REQ-016 SHALL have port feat_din  output  DATA_WIDTH  feature BRAM port-A write data.

Function
REQ-017 SHALL implement states IDLE, RD_ADDR, RD_DATA, WRITE, ALL_DONE with registered state.
REQ-018 SHALL transition IDLE->RD_ADDR when start=1; otherwise remain in IDLE.
REQ-019 SHALL, in IDLE with start=1, clear ch_pos, win_pos and the running-max register to 0.
REQ-020 SHALL drive conv_rd_addr = ch_pos*POOL_SIZE + win_pos, registered, stable through RD_ADDR and RD_DATA; transition RD_ADDR->RD_DATA unconditionally.
REQ-021 SHALL, in RD_DATA, load running-max with conv_rd_data when conv_rd_data (signed) > running-max; running-max starts at 0, which implements ReLU.
REQ-022 SHALL, in RD_DATA, go to WRITE when win_pos==POOL_SIZE-1, else increment win_pos and go to RD_ADDR.
REQ-023 SHALL, in WRITE, assert feat_wen=1 for exactly one cycle with feat_addr=ch_pos and feat_din=sat(running-max >>> SHIFT).
REQ-024 SHALL saturate: if shifted value > 2^(DATA_WIDTH-1)-1, feat_din = 2^(DATA_WIDTH-1)-1; otherwise use the low DATA_WIDTH bits. The result is never negative.
REQ-025 SHALL, in WRITE, clear running-max and win_pos. If ch_pos==NUM_CHANNELS-1, go to ALL_DONE; else increment ch_pos and go to RD_ADDR.
REQ-026 SHALL assert done=1 only in ALL_DONE, for one cycle, then return to IDLE.
REQ-027 SHALL hold feat_wen=0 in every state except WRITE.
REQ-028 SHALL ignore start while busy=1; start held high through ALL_DONE begins a new pass on the following IDLE cycle.
REQ-029 SHALL exhibit fixed latency: start sampled at edge N gives done high in cycle N+1+NUM_CHANNELS*(2*POOL_SIZE+1), which is N+55 at defaults.
REQ-030 SHALL use 2*POOL_SIZE+1 cycles per channel, with no bubbles between channels.

Reset
REQ-031 SHALL, on rst_n=0, immediately force state=IDLE and clear busy, done, feat_wen, feat_addr, feat_din, conv_rd_addr, ch_pos, win_pos and running-max to 0.
REQ-032 SHALL abort a pass when reset is asserted mid-pass: no further feat_wen pulse, and no done for the aborted pass.
REQ-033 SHALL require a fresh start after reset release; no pass resumes.

Verification
REQ-034 Basic: ch0 words {100,-5000,2560,512}, all other channels {0,0,0,0}, start 1 cycle -> feat_wen at addr 0 with din=10; addrs 1..5 with din=0; done at start+55.
REQ-035 ReLU: ch3 words all negative {-1,-256,-2^31,-7} -> write addr 3 with din=0.
REQ-036 Extremes: ch5 word 0x7FFFFFFF -> din=8388607 at addr 5. Rebuild with SHIFT=4 and word 0x10000000 -> din clamped to 8388607.
REQ-037 Address/timing: check conv_rd_addr sequence 0..23 in order, each held 2 cycles; exactly 6 feat_wen pulses at addrs 0..5, spaced 9 cycles apart.
REQ-038 Start during busy: pulse start at cycles +10 and +30 -> exactly one done, at +55, and no restart.
REQ-039 Reset mid-pass: assert rst_n=0 after the addr-2 write -> all outputs 0 immediately, no further writes, no done; new start -> full correct pass.
